// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - instruction cache miss refill controller (request, beat collection, line write)
// Optional ICACHE_FILL_PERF_EN adds saturating miss and stall-cycle counters.
module icache_fill_ctrl #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int MEM_DATA_W  = 32
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   i_fetch_req,
  input  logic [ADDR_WIDTH-1:0]  i_fetch_addr,
  input  logic                   i_hit,
  input  logic                   i_instr_addr_ma,
  output logic [ADDR_WIDTH-1:0]  o_cache_addr,
  output logic                   o_cache_we,
  output logic [BLOCK_WIDTH-1:0] o_cache_line,
  output logic                   o_stall,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_rvalid,
  input  logic [MEM_DATA_W-1:0]  i_mem_rdata
`ifdef ICACHE_FILL_PERF_EN
  ,
  output logic [31:0]            o_miss_count,
  output logic [31:0]            o_stall_cycles
`endif
);

  localparam int BEATS      = BLOCK_WIDTH / MEM_DATA_W;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_OFF_W = $clog2(BLOCK_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

  state_t                                 state_q, state_d;
  logic [CNT_W-1:0]                       cnt_q;
  logic [ADDR_WIDTH-1:0]                  addr_q;
  logic [BEATS-1:0][MEM_DATA_W-1:0]       line_q;
  logic                                   miss;
  logic                                   beat;

  assign miss = i_fetch_req & ~i_hit & ~i_instr_addr_ma;
  assign beat = (state_q == FILL) & i_mem_rvalid;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && miss)
        addr_q <= {i_fetch_addr[ADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
      if (state_q == REQ && i_mem_req_ready)
        cnt_q <= '0;
      else if (beat)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Line buffer carries no reset: a partial line is simply never written out.
  always_ff @(posedge clk) begin
    if (beat)
      line_q[cnt_q] <= i_mem_rdata;
  end

  always_comb begin
    state_d         = state_q;
    o_cache_addr    = i_fetch_addr;
    o_cache_we      = 1'b0;
    o_mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss)
          state_d = REQ;
      end
      REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready)
          state_d = FILL;
      end
      FILL: begin
        if (beat && cnt_q == CNT_W'(BEATS - 1))
          state_d = WRITE;
      end
      WRITE: begin
        o_cache_we   = 1'b1;
        o_cache_addr = addr_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_mem_addr   = addr_q;
  assign o_cache_line = line_q;
  assign o_stall      = (state_q != IDLE) | miss;

`ifdef ICACHE_FILL_PERF_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_miss_count   <= '0;
      o_stall_cycles <= '0;
    end else begin
      if (state_q == IDLE && miss && o_miss_count != 32'hFFFF_FFFF)
        o_miss_count <= o_miss_count + 1'b1;
      if (o_stall && o_stall_cycles != 32'hFFFF_FFFF)
        o_stall_cycles <= o_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb/tb_icache_fill_ctrl.sv - randomized refill bench against a transaction-level cache/memory model
module tb_icache_fill_ctrl;
  localparam int AW    = 64;
  localparam int BW    = 512;
  localparam int DW    = 32;
  localparam int BEATS = BW / DW;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          i_fetch_req = 1'b0;
  logic [AW-1:0] i_fetch_addr = '0;
  logic          i_hit = 1'b0;
  logic          i_instr_addr_ma = 1'b0;
  logic [AW-1:0] o_cache_addr;
  logic          o_cache_we;
  logic [BW-1:0] o_cache_line;
  logic          o_stall;
  logic          o_mem_req_valid;
  logic          i_mem_req_ready = 1'b0;
  logic [AW-1:0] o_mem_addr;
  logic          i_mem_rvalid = 1'b0;
  logic [DW-1:0] i_mem_rdata = '0;
`ifdef ICACHE_FILL_PERF_EN
  logic [31:0]   o_miss_count;
  logic [31:0]   o_stall_cycles;
`endif

  int   checks = 0;
  int   errors = 0;
  int   we_seen = 0;
  int   we_exp = 0;
  int   miss_m = 0;
  int   stall_m = 0;
  logic exp_stall = 1'b0;
  bit   cached [logic [AW-1:0]];

  icache_fill_ctrl dut (
    .clk             (clk),
    .arst            (arst),
    .i_fetch_req     (i_fetch_req),
    .i_fetch_addr    (i_fetch_addr),
    .i_hit           (i_hit),
    .i_instr_addr_ma (i_instr_addr_ma),
    .o_cache_addr    (o_cache_addr),
    .o_cache_we      (o_cache_we),
    .o_cache_line    (o_cache_line),
    .o_stall         (o_stall),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_addr      (o_mem_addr),
    .i_mem_rvalid    (i_mem_rvalid),
    .i_mem_rdata     (i_mem_rdata)
`ifdef ICACHE_FILL_PERF_EN
    ,
    .o_miss_count    (o_miss_count),
    .o_stall_cycles  (o_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Expected stall for the current cycle is accumulated at the edge that closes it.
  always @(posedge clk) begin
    if (arst) stall_m = 0;
    else if (exp_stall) stall_m++;
    if (!arst && o_cache_we === 1'b1) we_seen++;
  end

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] blk(input logic [AW-1:0] a);
    return {a[AW-1:6], 6'b0};
  endfunction

  task automatic fetch_idle(input logic [AW-1:0] addr, input logic ma);
    i_fetch_req = 1'b1; i_fetch_addr = addr; i_instr_addr_ma = ma;
    i_hit = 1'(cached.exists(blk(addr)));
    i_mem_rvalid = 1'($urandom_range(0, 1)); i_mem_rdata = $urandom;
    exp_stall = 1'b0;
    #1;
    check("idle_stall", BW'(o_stall), BW'(0));
    check("idle_cache_addr", BW'(o_cache_addr), BW'(addr));
    next();
    check("idle_no_req", BW'(o_mem_req_valid), BW'(0));
    i_fetch_req = 1'b0; i_instr_addr_ma = 1'b0; i_mem_rvalid = 1'b0;
    #1;
    check("idle_no_req2", BW'(o_mem_req_valid), BW'(0));
  endtask

  task automatic refill(input logic [AW-1:0] addr, input bit directed, input int ready_dly, input int abort_at);
    logic [BW-1:0] line_m;
    logic [DW-1:0] w;
    int gap;
    line_m = '0;
    i_fetch_req = 1'b1; i_fetch_addr = addr; i_hit = 1'b0; i_instr_addr_ma = 1'b0;
    exp_stall = 1'b1; miss_m++;
    #1;
    check("miss_stall", BW'(o_stall), BW'(1));
    check("miss_no_valid_yet", BW'(o_mem_req_valid), BW'(0));
    next();
    for (int d = 0; d <= ready_dly; d++) begin
      i_fetch_req = 1'($urandom_range(0, 1)); i_fetch_addr = {$urandom, $urandom};
      i_mem_req_ready = (d == ready_dly);
      i_mem_rvalid = 1'($urandom_range(0, 1)); i_mem_rdata = $urandom;
      #1;
      check("req_valid", BW'(o_mem_req_valid), BW'(1));
      check("req_addr", BW'(o_mem_addr), BW'(blk(addr)));
      check("req_stall", BW'(o_stall), BW'(1));
      next();
    end
    i_mem_req_ready = 1'b0; i_mem_rvalid = 1'b0;
    #1;
    check("valid_drop", BW'(o_mem_req_valid), BW'(0));
    for (int b = 0; b < BEATS; b++) begin
      gap = directed ? ((b == 5 || b == 10) ? 3 : 0) : $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        i_mem_rvalid = 1'b0; i_fetch_addr = {$urandom, $urandom};
        next();
      end
      if (b == abort_at) begin
        arst = 1'b1; exp_stall = 1'b0; i_fetch_req = 1'b0; i_mem_rvalid = 1'b0; miss_m = 0;
        #1;
        check("abort_we", BW'(o_cache_we), BW'(0));
        check("abort_valid", BW'(o_mem_req_valid), BW'(0));
        check("abort_stall", BW'(o_stall), BW'(0));
        check("abort_mem_addr", BW'(o_mem_addr), BW'(0));
        next();
        arst = 1'b0;
        return;
      end
      w = directed ? DW'(32'h1000 + b) : DW'($urandom);
      line_m[b*DW +: DW] = w;
      i_mem_rvalid = 1'b1; i_mem_rdata = w;
      #1;
      check("fill_no_we", BW'(o_cache_we), BW'(0));
      next();
    end
    i_mem_rvalid = 1'($urandom_range(0, 1)); i_mem_rdata = $urandom;
    i_fetch_addr = {$urandom, $urandom};
    #1;
    check("we_pulse", BW'(o_cache_we), BW'(1));
    check("we_addr", BW'(o_cache_addr), BW'(blk(addr)));
    check("we_line", o_cache_line, line_m);
    check("write_stall", BW'(o_stall), BW'(1));
    if (directed) begin
      check("line_lo", BW'(o_cache_line[31:0]), BW'(32'h1000));
      check("line_hi", BW'(o_cache_line[511:480]), BW'(32'h100F));
    end
    we_exp++;
    cached[blk(addr)] = 1'b1;
    next();
    i_mem_rvalid = 1'b0;
    fetch_idle(addr, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic ma;
    next();
    next();
    check("rst_valid", BW'(o_mem_req_valid), BW'(0));
    check("rst_we", BW'(o_cache_we), BW'(0));
    check("rst_mem_addr", BW'(o_mem_addr), BW'(0));
    check("rst_stall", BW'(o_stall), BW'(0));
`ifdef ICACHE_FILL_PERF_EN
    check("rst_miss_cnt", BW'(o_miss_count), BW'(0));
    check("rst_stall_cnt", BW'(o_stall_cycles), BW'(0));
`endif
    arst = 1'b0;
    next();

    refill(64'h0000_0000_0000_1004, 1'b1, 5, -1);
    fetch_idle(64'h0000_0000_0000_2000, 1'b1);
    refill(64'h0000_0000_0000_3010, 1'b0, 1, 8);
    refill(64'h0000_0000_0000_3010, 1'b1, 0, -1);

    for (int n = 0; n < 30; n++) begin
      a  = 64'h8000_0000 + 64'($urandom_range(0, 5)) * 64 + 64'($urandom_range(0, 63));
      ma = ($urandom_range(0, 4) == 0);
      if (ma || cached.exists(blk(a))) fetch_idle(a, ma);
      else refill(a, 1'b0, $urandom_range(0, 4), -1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        i_fetch_req = 1'b0; exp_stall = 1'b0;
        next();
      end
    end

    exp_stall = 1'b0;
    next();
    check("we_pulse_count", BW'(we_seen), BW'(we_exp));
`ifdef ICACHE_FILL_PERF_EN
    check("miss_count", BW'(o_miss_count), BW'(miss_m));
    check("stall_cycles", BW'(o_stall_cycles), BW'(stall_m));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
Miss-handling controller for the direct-mapped instruction cache. It detects a fetch miss and issues one block-aligned read request to the memory side. It then collects BLOCK_WIDTH/MEM_DATA_W data beats into a line buffer and writes the completed line into the cache with a single one-cycle write strobe. It sits between the fetch stage, the instruction cache and the memory/bus interface, and stalls fetch for the whole refill.

Parameters:
ADDR_WIDTH, 64, fetch/memory address width
BLOCK_WIDTH, 512, cache line width in bits
MEM_DATA_W, 32, memory read beat width in bits; BLOCK_WIDTH must be an integer multiple
(derived) BEATS = BLOCK_WIDTH/MEM_DATA_W (16); CNT_W = $clog2(BEATS); LINE_OFF_W = $clog2(BLOCK_WIDTH/8) (6)

Ports:
clk  in  1  clock
arst  in  1  asynchronous reset, active-high
i_fetch_req  in  1  fetch stage requests an instruction this cycle
i_fetch_addr  in  ADDR_WIDTH  fetch address
i_hit  in  1  cache hit for the address on o_cache_addr
i_instr_addr_ma  in  1  cache misaligned-fetch flag; suppresses refill
o_cache_addr  out  ADDR_WIDTH  address driven to the cache
o_cache_we  out  1  cache write enable, one cycle per refill
o_cache_line  out  BLOCK_WIDTH  assembled line to the cache
o_stall  out  1  fetch must hold
o_mem_req_valid  out  1  read request valid
i_mem_req_ready  in  1  memory accepts request
o_mem_addr  out  ADDR_WIDTH  block-aligned request address (low LINE_OFF_W bits zero)
i_mem_rvalid  in  1  read beat valid
i_mem_rdata  in  MEM_DATA_W  read beat data, lowest address first

Behaviour:
- Reset values: state=IDLE, beat counter=0, latched address=0, o_cache_we=0, o_mem_req_valid=0, o_mem_addr=0. The line buffer is not required to clear. o_stall is combinational.
- States: IDLE, REQ, FILL, WRITE.
- IDLE:
  - o_cache_addr=i_fetch_addr.
  - If i_fetch_req & ~i_hit & ~i_instr_addr_ma: latch {i_fetch_addr[ADDR_WIDTH-1:LINE_OFF_W], zeros} and go to REQ.
  - A hit, no request, or a misaligned fetch keeps the block in IDLE.
- REQ:
  - o_mem_req_valid=1 and o_mem_addr=latched address, both held stable until accepted.
  - On i_mem_req_ready: counter=0, go to FILL. Valid drops in the cycle after acceptance.
- FILL:
  - Each i_mem_rvalid writes i_mem_rdata into line[cnt*MEM_DATA_W +: MEM_DATA_W] and increments cnt.
  - A beat with cnt==BEATS-1 goes to WRITE. Cycles without rvalid are gaps: wait, no timeout.
- WRITE:
  - o_cache_we=1 for exactly one cycle; o_cache_addr=latched address; o_cache_line=line buffer.
  - Next state IDLE.
  - Refill latency is 1 (REQ) + memory latency + BEATS beats + 1 (WRITE). The retried fetch hits in the first IDLE cycle after WRITE.
- o_stall = (state!=IDLE) | (i_fetch_req & ~i_hit & ~i_instr_addr_ma).
- Outside FILL, i_mem_rvalid is ignored.
- Changes to i_fetch_addr or i_fetch_req during REQ/FILL/WRITE are ignored; the refill always completes for the latched address.
- i_fetch_req deasserting mid-refill does not abort the refill.
- arst asserted mid-refill returns the block to IDLE immediately with o_cache_we=0. Any partial line is discarded and never written.
- Counter arithmetic is CNT_W wide and wraps to 0 on entry to FILL only.

Optional Feature:
ICACHE_FILL_PERF_EN:
- Defined: adds output o_miss_count (32 bits, reset 0). It increments by 1 on each IDLE->REQ transition and saturates at 32'hFFFF_FFFF. It also adds o_stall_cycles (32 bits, reset 0), which increments every cycle o_stall=1 and saturates.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset, then fetch 0x0000_0000_0000_1004 with i_hit=0 -> o_mem_req_valid=1 and o_mem_addr=0x...1000 in the next cycle; o_stall=1 throughout.
- Hold i_mem_req_ready=0 for 5 cycles, then 1 -> o_mem_addr is stable over all 6 cycles and valid drops after acceptance.
- Return 16 beats of data 0x1000+i with 3-cycle gaps after beats 4 and 9 -> exactly one o_cache_we pulse, o_cache_line[31:0]=0x1000, [511:480]=0x100F, o_cache_addr=0x...1000 during the pulse.
- Fetch with i_instr_addr_ma=1 and i_hit=0 -> no memory request; stays in IDLE; o_stall=0.
- Assert arst after beat 7 -> state returns to IDLE, o_cache_we never pulses; a new miss restarts at beat 0.
- With ICACHE_FILL_PERF_EN: three misses separated by hits -> o_miss_count=3; o_stall_cycles equals the summed stall cycles.
